// File: rtl/decryption_core.sv
// Iterative AES-128 decryption core: one inverse round per clock, 11-edge latency.
// Ports: clk, n_rst (async low), start/d_in in, key_schedule w[0..43] in, busy/done/d_out out.
module decryption_core #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         start,
  input  logic [127:0] d_in,
  input  logic [31:0]  key_schedule [0:4*NR+3],
  output logic         busy,
  output logic         done,
  output logic [127:0] d_out
);

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    FINAL
  } fsm_e;

  fsm_e         fsm_q, fsm_d;
  logic [127:0] st_q, st_d;
  logic [127:0] d_out_q, d_out_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  logic [127:0] rk;
  logic [127:0] isb;
  logic [127:0] pre;
  logic [127:0] imc;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as AES requires.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] x2, x3, x6, x12, x15;
    logic [7:0] x30, x60, x120, x240;
    x2   = gmul(a, a);
    x3   = gmul(x2, a);
    x6   = gmul(x3, x3);
    x12  = gmul(x6, x6);
    x15  = gmul(x12, x3);
    x30  = gmul(x15, x15);
    x60  = gmul(x30, x30);
    x120 = gmul(x60, x60);
    x240 = gmul(x120, x120);
    return gmul(gmul(x240, x12), x2);
  endfunction

  // Undo the affine map first, then invert in GF(2^8).
  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) begin
      b[i] = a[(i+2)%8] ^ a[(i+5)%8] ^ a[(i+7)%8];
    end
    return ginv(b ^ 8'h05);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      x2    = xt(a[i]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // rnd_q reaches 0 in FINAL, so the same mux yields w[0..3] there.
  always_comb begin
    rk = {key_schedule[{rnd_q, 2'b00}],
          key_schedule[{rnd_q, 2'b01}],
          key_schedule[{rnd_q, 2'b10}],
          key_schedule[{rnd_q, 2'b11}]};
  end

  // Byte i sits at row i%4, col i/4; row r takes from col (c-r) mod 4.
  always_comb begin
    isb = '0;
    for (int i = 0; i < 16; i++) begin
      isb[127-8*i -: 8] = inv_sbox(
        st_q[127-8*((i%4) + 4*(((i/4) - (i%4)) & 3)) -: 8]);
    end
  end

  assign pre = isb ^ rk;

  always_comb begin
    imc = '0;
    for (int c = 0; c < 4; c++) begin
      imc[127-32*c -: 32] = inv_mix_col(pre[127-32*c -: 32]);
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    st_d    = st_q;
    rnd_d   = rnd_q;
    d_out_d = d_out_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (fsm_q)
      IDLE: begin
        if (start) begin
          st_d   = d_in ^ {key_schedule[4*NR],
                           key_schedule[4*NR+1],
                           key_schedule[4*NR+2],
                           key_schedule[4*NR+3]};
          rnd_d  = 4'(NR - 1);
          busy_d = 1'b1;
          fsm_d  = ROUND;
        end
      end
      ROUND: begin
        st_d  = imc;
        rnd_d = rnd_q - 4'd1;
        if (rnd_q == 4'd1) fsm_d = FINAL;
      end
      FINAL: begin
        d_out_d = pre;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        fsm_d   = IDLE;
      end
      default: begin
        fsm_d  = IDLE;
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      fsm_q   <= IDLE;
      st_q    <= '0;
      rnd_q   <= '0;
      d_out_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      st_q    <= st_d;
      rnd_q   <= rnd_d;
      d_out_q <= d_out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign d_out = d_out_q;

endmodule
